// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  cache_pkg
//  Shared widths, beat bookkeeping constants and FSM state type for
//  cacheline_adaptor.
//  Revision: 1.0
// ============================================================================
package cache_pkg;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int ADDR_W      = 32;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = 2;

  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  cacheline_adaptor
//  Converts 256-bit cache line fills/writebacks into four-beat 64-bit memory
//  bursts. Optional SVA checks: define CACHELINE_ADAPTOR_ASSERT_EN.
//  Revision: 1.0
// ============================================================================
module cacheline_adaptor
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [LINE_W-1:0]    line_i,
  output logic [LINE_W-1:0]    line_o,
  output logic                 resp_o,
  output logic [ADDR_W-1:0]    address_o,
  output logic                 read_o,
  output logic                 write_o,
  output logic [BURST_W-1:0]   burst_o,
  input  logic [BURST_W-1:0]   burst_i,
  input  logic                 resp_i
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [LINE_W-1:0]   buf_q,   buf_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests arrive together.
        if (write_i) begin
          state_d = WRITE;
          addr_d  = address_i & ~OFFSET_MASK;
          cnt_d   = '0;
          buf_d   = line_i;
        end else if (read_i) begin
          state_d = READ;
          addr_d  = address_i & ~OFFSET_MASK;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (resp_i) begin
          buf_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  assign line_o    = buf_q;
  assign address_o = addr_q;
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign burst_o   = (state_q == WRITE) ? buf_q[int'(cnt_q)*BURST_W +: BURST_W] : '0;

`ifdef CACHELINE_ADAPTOR_ASSERT_EN
  a_resp_only_in_burst: assert property (@(posedge clk) disable iff (rst)
    resp_i |-> (read_o || write_o));
  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(read_o && write_o));
  a_resp_one_cycle: assert property (@(posedge clk) disable iff (rst)
    resp_o |=> !resp_o);
  a_no_x_ctrl: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({resp_o, read_o, write_o}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  tb_cacheline_adaptor
//  Directed and randomized line fill / writeback traffic against a
//  beat-level reference model of the cache-to-memory bridge.
//  Revision: 1.0
// ============================================================================
module tb_cacheline_adaptor;
  import cache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ADDR_W-1:0]    address_i;
  logic                 read_i;
  logic                 write_i;
  logic [LINE_W-1:0]    line_i;
  logic [LINE_W-1:0]    line_o;
  logic                 resp_o;
  logic [ADDR_W-1:0]    address_o;
  logic                 read_o;
  logic                 write_o;
  logic [BURST_W-1:0]   burst_o;
  logic [BURST_W-1:0]   burst_i;
  logic                 resp_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are register-driven so they are stable here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [BURST_W-1:0] beat_of(input logic [LINE_W-1:0] l, input int b);
    logic [LINE_W-1:0] sh;
    sh = l >> (BURST_W * b);
    return sh[BURST_W-1:0];
  endfunction

  // Full line fill: memory returns mem_line beat by beat, stalling between beats.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] mem_line,
                         input int stall, input bit keep_req);
    read_i    = 1'b1;
    address_i = addr;
    resp_i    = 1'b0;
    cyc       = 0;
    tick();
    address_i = $urandom;
    check("rd_start_read_o", read_o, 1);
    check("rd_address_o", address_o, addr & 32'hFFFF_FFE0);
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) begin
        for (int s = 0; s < stall; s++) begin
          resp_i  = 1'b0;
          burst_i = {$urandom, $urandom};
          tick();
          check("rd_stall_read_o", read_o, 1);
          check("rd_stall_resp_o", resp_o, 0);
        end
      end
      resp_i  = 1'b1;
      burst_i = beat_of(mem_line, b);
      tick();
      if (b < BEATS - 1) check("rd_mid_read_o", read_o, 1);
    end
    resp_i  = 1'b0;
    read_i  = keep_req;
    check("rd_done_resp_o", resp_o, 1);
    check("rd_done_read_o", read_o, 0);
    check("rd_latency", cyc, 1 + BEATS + stall * (BEATS - 1));
    check("rd_line_o", line_o, mem_line);
    tick();
    check("rd_resp_pulse_end", resp_o, 0);
    check("rd_line_hold", line_o, mem_line);
  endtask

  // Full writeback; optionally holds read_i high alongside write_i.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wline,
                          input int stall, input bit with_read);
    write_i   = 1'b1;
    read_i    = with_read;
    address_i = addr;
    line_i    = wline;
    resp_i    = 1'b0;
    cyc       = 0;
    tick();
    address_i = $urandom;
    line_i    = rand_line();
    check("wr_start_write_o", write_o, 1);
    check("wr_start_read_o", read_o, 0);
    check("wr_address_o", address_o, addr & 32'hFFFF_FFE0);
    check("wr_line_o", line_o, wline);
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) begin
        for (int s = 0; s < stall; s++) begin
          resp_i = 1'b0;
          tick();
          check("wr_stall_write_o", write_o, 1);
          check("wr_stall_burst_o", burst_o, beat_of(wline, b));
        end
      end
      check("wr_burst_o", burst_o, beat_of(wline, b));
      resp_i = 1'b1;
      tick();
    end
    resp_i  = 1'b0;
    write_i = 1'b0;
    check("wr_done_resp_o", resp_o, 1);
    check("wr_done_write_o", write_o, 0);
    check("wr_latency", cyc, 1 + BEATS + stall * (BEATS - 1));
    tick();
    check("wr_resp_pulse_end", resp_o, 0);
    check("wr_idle_read_o", read_o, 0);
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    rst       = 1'b1;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    tick();
    tick();

    check("rst_resp_o", resp_o, 0);
    check("rst_read_o", read_o, 0);
    check("rst_write_o", write_o, 0);
    check("rst_address_o", address_o, 0);
    check("rst_burst_o", burst_o, 0);
    check("rst_line_o", line_o, 0);
    rst = 1'b0;

    // Stray memory strobes while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      tick();
      check("idle_resp_o", resp_o, 0);
      check("idle_read_o", read_o, 0);
      check("idle_write_o", write_o, 0);
      check("idle_line_o", line_o, 0);
    end
    resp_i = 1'b0;

    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, l, 0, 1'b0);

    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_write(32'h0000_5678, l, 0, 1'b0);

    do_read(32'h8000_00FF, rand_line(), 3, 1'b0);

    // Simultaneous requests: write first, then the held read.
    l = rand_line();
    do_write(32'h0000_0040, l, 1, 1'b1);
    do_read(32'h0000_0080, rand_line(), 0, 1'b0);

    // Reset after the second beat of a read discards the partial line.
    read_i    = 1'b1;
    address_i = 32'hCAFE_F00D;
    tick();
    for (int b = 0; b < 2; b++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    rst    = 1'b1;
    tick();
    check("rst_mid_read_o", read_o, 0);
    check("rst_mid_line_o", line_o, 0);
    check("rst_mid_address_o", address_o, 0);
    check("rst_mid_resp_o", resp_o, 0);
    rst = 1'b0;
    tick();
    do_read(32'h0000_1234, rand_line(), 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, rand_line(), int'($urandom_range(0, 2)), 1'b0);
      else
        do_write($urandom, rand_line(), int'($urandom_range(0, 2)), 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
